// File: rtl/arcdvi_ctrl_regs_pkg.sv
// Shared definitions for the ArcDVI control/status register block:
// register word indices, CTRL bit positions and the PLL serialiser states.
package arcdvi_ctrl_regs_pkg;

    localparam logic [3:0] ADDR_ID      = 4'd0;
    localparam logic [3:0] ADDR_CTRL    = 4'd1;
    localparam logic [3:0] ADDR_LED     = 4'd2;
    localparam logic [3:0] ADDR_TX      = 4'd3;
    localparam logic [3:0] ADDR_RX      = 4'd4;
    localparam logic [3:0] ADDR_PLLSTAT = 4'd5;
    localparam logic [3:0] ADDR_FMSTAT  = 4'd6;
    localparam logic [3:0] ADDR_FM_BASE = 4'd8;

    localparam int CTRL_PCLK_RESET = 0;
    localparam int CTRL_PLL_NRESET = 1;
    localparam int CTRL_LOCKED     = 4;
    localparam int CTRL_BYPASS     = 6;

    typedef enum logic [1:0] {
        SER_IDLE = 2'd0,
        SER_LOW  = 2'd1,
        SER_HIGH = 2'd2,
        SER_DONE = 2'd3
    } ser_state_t;

    // Assemble the CTRL read word from its individual control/status bits.
    function automatic logic [31:0] ctrl_word(input logic pclk_rst, input logic nrst,
                                              input logic locked, input logic bypass);
        logic [31:0] w;
        w                  = '0;
        w[CTRL_PCLK_RESET] = pclk_rst;
        w[CTRL_PLL_NRESET] = nrst;
        w[CTRL_LOCKED]     = locked;
        w[CTRL_BYPASS]     = bypass;
        return w;
    endfunction

endpackage

// File: rtl/arcdvi_ctrl_regs_if.sv
// Register bus between the SPI register bridge (master) and the control
// register file (slave). Read data is combinational from the address.
interface arcdvi_ctrl_regs_if;
    logic        reg_valid;
    logic        reg_wen;
    logic [3:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;

    modport master (
        output reg_valid, reg_wen, reg_addr, reg_wdata,
        input  reg_rdata
    );

    modport slave (
        input  reg_valid, reg_wen, reg_addr, reg_wdata,
        output reg_rdata
    );
endinterface

// File: rtl/arcdvi_ctrl_regs_freq_meter.sv
// One frequency-meter channel: synchronises an async input, detects rising
// edges, counts them with saturation and latches the count on each gate end.
module arcdvi_ctrl_regs_freq_meter
    import arcdvi_ctrl_regs_pkg::*;
#(
    parameter int FM_W = 24
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fm_in,
    input  logic            gate_term,
    output logic [FM_W-1:0] result
);

    localparam logic [FM_W-1:0] CNT_MAX = '1;

    logic            sync1;
    logic            sync2;
    logic            prev;
    logic            rise;
    logic [FM_W-1:0] count;
    logic [FM_W-1:0] count_inc;

    assign rise      = sync2 & ~prev;
    assign count_inc = (rise && (count != CNT_MAX)) ? count + FM_W'(1) : count;

    // Sync + edge detect, then count edges; the terminal gate cycle includes its own edge in the result.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            prev   <= 1'b0;
            count  <= '0;
            result <= '0;
        end else begin
            sync1 <= fm_in;
            sync2 <= sync1;
            prev  <= sync2;
            if (gate_term) begin
                result <= count_inc;
                count  <= '0;
            end else begin
                count <= count_inc;
            end
        end
    end

endmodule

// File: rtl/arcdvi_ctrl_regs.sv
// ArcDVI control/status register file: ID, CTRL, LED, PLL config serialiser
// (replaces bit-banging the PLL config port) and a multi-channel frequency meter.
module arcdvi_ctrl_regs
    import arcdvi_ctrl_regs_pkg::*;
#(
    parameter logic [31:0] ID_VAL      = 32'h00800002,
    parameter int          PLLCFG_BITS = 27,
    parameter int          SCLK_DIV    = 4,
    parameter int          NUM_LEDS    = 1,
    parameter int          NUM_FM      = 2,
    parameter int          FM_GATE     = 62500,
    parameter int          FM_W        = 24
) (
    input  logic                clk,
    input  logic                reset,
    arcdvi_ctrl_regs_if.slave   bus,
    output logic                pclk_reset,
    output logic                pll_nreset,
    output logic                pll_bypass,
    input  logic                pll_locked,
    output logic                pll_sdi,
    output logic                pll_sclk,
    input  logic                pll_sdo,
    output logic [NUM_LEDS-1:0] led,
    input  logic [NUM_FM-1:0]   fm_in
);

    localparam int DIV_W  = (SCLK_DIV > 1)    ? $clog2(SCLK_DIV)    : 1;
    localparam int IDX_W  = (PLLCFG_BITS > 1) ? $clog2(PLLCFG_BITS) : 1;
    localparam int GATE_W = (FM_GATE > 1)     ? $clog2(FM_GATE)     : 1;

    logic                   wr_en;
    logic [31:0]            tx_q;
    logic [PLLCFG_BITS-1:0] rx_q;
    logic [PLLCFG_BITS-1:0] rx_next;
    logic [PLLCFG_BITS-1:0] shift_q;
    logic [PLLCFG_BITS-1:0] shift_next;
    logic                   locked_s1;
    logic                   locked_s2;
    logic                   sdo_s1;
    logic                   sdo_s2;

    ser_state_t             state;
    logic                   busy;
    logic [DIV_W-1:0]       div_cnt;
    logic                   div_last;
    logic [IDX_W-1:0]       bit_idx;
    logic                   start_req;

    logic [GATE_W-1:0]      gate_cnt;
    logic                   gate_term;
    logic [NUM_FM-1:0]      fresh;
    logic [NUM_FM-1:0]      fresh_clr;
    logic [FM_W-1:0]        fm_result [NUM_FM];

    assign wr_en      = bus.reg_valid && bus.reg_wen;
    assign start_req  = wr_en && (bus.reg_addr == ADDR_PLLSTAT) && bus.reg_wdata[0];
    assign fresh_clr  = (wr_en && (bus.reg_addr == ADDR_FMSTAT)) ? bus.reg_wdata[NUM_FM-1:0] : '0;
    assign div_last   = (div_cnt == DIV_W'(SCLK_DIV - 1));
    assign gate_term  = (gate_cnt == GATE_W'(FM_GATE - 1));
    assign shift_next = shift_q << 1;
    assign rx_next    = (rx_q << 1) | PLLCFG_BITS'(sdo_s2);

    // Writable control registers; RO and unmapped words simply ignore writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            pclk_reset <= 1'b1;
            pll_nreset <= 1'b0;
            pll_bypass <= 1'b0;
            led        <= '0;
            tx_q       <= '0;
        end else if (wr_en) begin
            case (bus.reg_addr)
                ADDR_CTRL: begin
                    pclk_reset <= bus.reg_wdata[CTRL_PCLK_RESET];
                    pll_nreset <= bus.reg_wdata[CTRL_PLL_NRESET];
                    pll_bypass <= bus.reg_wdata[CTRL_BYPASS];
                end
                ADDR_LED: led  <= bus.reg_wdata[NUM_LEDS-1:0];
                ADDR_TX:  tx_q <= bus.reg_wdata;
                default: ;
            endcase
        end
    end

    // Two-flop synchronisers for the asynchronous PLL lock and config-readback inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            locked_s1 <= 1'b0;
            locked_s2 <= 1'b0;
            sdo_s1    <= 1'b0;
            sdo_s2    <= 1'b0;
        end else begin
            locked_s1 <= pll_locked;
            locked_s2 <= locked_s1;
            sdo_s1    <= pll_sdo;
            sdo_s2    <= sdo_s1;
        end
    end

    // PLL config serialiser: shifts a private copy of TX out MSB first, so TX writes mid-transfer are harmless.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= SER_IDLE;
            busy     <= 1'b0;
            pll_sclk <= 1'b0;
            pll_sdi  <= 1'b0;
            div_cnt  <= '0;
            bit_idx  <= '0;
            shift_q  <= '0;
            rx_q     <= '0;
        end else begin
            case (state)
                SER_IDLE: begin
                    if (start_req) begin
                        state    <= SER_LOW;
                        busy     <= 1'b1;
                        pll_sclk <= 1'b0;
                        pll_sdi  <= tx_q[PLLCFG_BITS-1];
                        shift_q  <= tx_q[PLLCFG_BITS-1:0];
                        div_cnt  <= '0;
                        bit_idx  <= IDX_W'(PLLCFG_BITS - 1);
                    end
                end
                SER_LOW: begin
                    if (div_last) begin
                        state    <= SER_HIGH;
                        pll_sclk <= 1'b1;
                        div_cnt  <= '0;
                        rx_q     <= rx_next;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                SER_HIGH: begin
                    if (div_last) begin
                        div_cnt  <= '0;
                        pll_sclk <= 1'b0;
                        if (bit_idx != '0) begin
                            state   <= SER_LOW;
                            bit_idx <= bit_idx - IDX_W'(1);
                            shift_q <= shift_next;
                            pll_sdi <= shift_next[PLLCFG_BITS-1];
                        end else begin
                            state   <= SER_DONE;
                            pll_sdi <= 1'b0;
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                SER_DONE: begin
                    state <= SER_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= SER_IDLE;
            endcase
        end
    end

    // Shared gate counter; its terminal cycle latches every channel at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            gate_cnt <= '0;
        end else if (gate_term) begin
            gate_cnt <= '0;
        end else begin
            gate_cnt <= gate_cnt + GATE_W'(1);
        end
    end

    // Fresh flags: write-1-to-clear, but a same-cycle new result keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            fresh <= '0;
        end else begin
            fresh <= (fresh & ~fresh_clr) | {NUM_FM{gate_term}};
        end
    end

    for (genvar g = 0; g < NUM_FM; g++) begin : g_fm
        arcdvi_ctrl_regs_freq_meter #(
            .FM_W (FM_W)
        ) u_fm (
            .clk       (clk),
            .reset     (reset),
            .fm_in     (fm_in[g]),
            .gate_term (gate_term),
            .result    (fm_result[g])
        );
    end

    // Combinational read decode; unmapped words read as zero.
    always_comb begin
        bus.reg_rdata = '0;
        case (bus.reg_addr)
            ADDR_ID:      bus.reg_rdata = ID_VAL;
            ADDR_CTRL:    bus.reg_rdata = ctrl_word(pclk_reset, pll_nreset, locked_s2, pll_bypass);
            ADDR_LED:     bus.reg_rdata = 32'(led);
            ADDR_TX:      bus.reg_rdata = tx_q;
            ADDR_RX:      bus.reg_rdata = 32'(rx_q);
            ADDR_PLLSTAT: bus.reg_rdata = {31'b0, busy};
            ADDR_FMSTAT:  bus.reg_rdata = 32'(fresh);
            default: begin
                for (int i = 0; i < NUM_FM; i++) begin
                    if (bus.reg_addr == (ADDR_FM_BASE + 4'(i))) begin
                        bus.reg_rdata = 32'(fm_result[i]);
                    end
                end
            end
        endcase
    end

endmodule
